// File: rtl/emu_video_capture.sv
// emu_video_capture: turns the emu pixel stream into linear framebuffer writes and measures each captured frame.
// Define CAPTURE_CRC_EN to add a per-frame CRC-16/CCITT of the written pixels on frame_crc.
module emu_video_capture #(
  parameter int MAX_W  = 640,
  parameter int MAX_H  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              CLK_VIDEO,
  input  logic              reset,
  input  logic              capture_en,
  input  logic              ce_pix,
  input  logic [7:0]        r,
  input  logic [7:0]        g,
  input  logic [7:0]        b,
  input  logic              hs,
  input  logic              vs,
  input  logic              hb,
  input  logic              vb,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [23:0]       fb_data,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic [10:0]       meas_width,
  output logic [9:0]        meas_height,
  output logic              clipped
`ifdef CAPTURE_CRC_EN
  ,
  output logic [15:0]       frame_crc
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_CAP} state_t;
  state_t state, state_n;
  logic [10:0] x, line_w;
  logic [9:0] y;
  logic hb_d, vb_d, clip;
  logic act, hb_rise, vb_rise, cap, sof, in_range, wr;
  logic [ADDR_W:0] addr_full;
  logic unused_ok;

  assign unused_ok = ^{hs, vs, addr_full[ADDR_W]};

  always_ff @(posedge CLK_VIDEO)
    state <= reset ? S_IDLE : state_n;

  always_comb
    state_n = state == S_IDLE ? (capture_en ? S_SYNC : S_IDLE) :
              state == S_SYNC ? (vb_rise ? S_CAP : S_SYNC) :
              (vb_rise && !capture_en ? S_IDLE : S_CAP);

  always_comb begin
    act       = ce_pix && !hb && !vb;
    hb_rise   = ce_pix && hb && !hb_d;
    vb_rise   = ce_pix && vb && !vb_d;
    cap       = state == S_CAP;
    sof       = vb_rise && state != S_IDLE;
    in_range  = {1'b0, x} < 12'(MAX_W) && {1'b0, y} < 11'(MAX_H);
    wr        = cap && act && in_range;
    addr_full = (ADDR_W+1)'(y) * (ADDR_W+1)'(MAX_W) + (ADDR_W+1)'(x);
  end

  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      fb_we       <= 1'b0;
      fb_addr     <= '0;
      fb_data     <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      meas_width  <= '0;
      meas_height <= '0;
      clipped     <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_w      <= '0;
      clip        <= 1'b0;
      hb_d        <= 1'b1;
      vb_d        <= 1'b1;
    end else begin
      fb_we      <= wr;
      frame_done <= cap && vb_rise;
      if (wr) begin
        fb_addr <= addr_full[ADDR_W-1:0];
        fb_data <= {r, g, b};
      end
      if (ce_pix) begin
        hb_d <= hb;
        vb_d <= vb;
      end
      // A line still open at vb counts toward the frame's measurement
      if (cap && vb_rise) begin
        meas_width  <= x != '0 ? x : line_w;
        meas_height <= x != '0 ? (&y ? y : y + 10'd1) : y;
        clipped     <= clip;
        frame_count <= frame_count + 16'd1;
      end
      if (sof) begin
        x    <= '0;
        y    <= '0;
        clip <= 1'b0;
      end else if (cap && act) begin
        x <= &x ? x : x + 11'd1;
        if (!in_range)
          clip <= 1'b1;
      end else if (cap && hb_rise && !vb && x != '0) begin
        line_w <= x;
        y      <= &y ? y : y + 10'd1;
        x      <= '0;
      end
    end
  end

`ifdef CAPTURE_CRC_EN
  logic [15:0] crc;

  function automatic logic [15:0] crc24(input logic [15:0] c, input logic [23:0] d);
    logic [15:0] n;
    n = c;
    for (int i = 23; i >= 0; i--)
      n = {n[14:0], 1'b0} ^ ((n[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return n;
  endfunction

  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      crc       <= 16'hFFFF;
      frame_crc <= '0;
    end else if (sof) begin
      if (cap)
        frame_crc <= crc;
      crc <= 16'hFFFF;
    end else if (wr) begin
      crc <= crc24(crc, {r, g, b});
    end
  end
`endif
endmodule
